// File: rtl/cla_pkg.sv
// Shared definitions for the shared-adder arbiter: default sizes, FSM state
// type and the operand-bus packing helper.
package cla_pkg;

    localparam int unsigned CLA_N_DEF = 32;
    localparam int unsigned NREQ_DEF  = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADD  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    // Base bit of requester idx inside a flattened bus of w-bit fields.
    function automatic int unsigned req_pack(input int unsigned idx, input int unsigned w);
        return idx * w;
    endfunction

endpackage

// File: rtl/cla_share_arb_cla_n.sv
// N-bit adder built from generate/propagate terms; PHI high parks the
// outputs at zero (precharge phase), PHI low evaluates.
module CLA_N #(
    parameter int unsigned N = 32
) (
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic         CIN,
    input  logic         PHI,
    output logic [N-1:0] SUM,
    output logic         COUT
);

    logic [N-1:0] g;
    logic [N-1:0] p;
    logic [N:0]   c;

    always_comb begin
        g    = A & B;
        p    = A ^ B;
        c    = '0;
        c[0] = CIN;
        for (int unsigned i = 0; i < N; i++) begin
            c[i+1] = g[i] | (p[i] & c[i]);
        end
        SUM  = PHI ? '0 : (p ^ c[N-1:0]);
        COUT = PHI ? 1'b0 : c[N];
    end

endmodule

// File: rtl/cla_share_arb_rr_arb.sv
// Combinational round-robin picker: first asserted request at or after ptr,
// wrapping modulo NREQ.
module rr_arb
    import cla_pkg::*;
#(
    parameter int unsigned NREQ = NREQ_DEF,
    parameter int unsigned ID_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [ID_W-1:0] ptr,
    output logic [NREQ-1:0] gnt,
    output logic [ID_W-1:0] gnt_id,
    output logic            any
);

    int unsigned idx;

    always_comb begin
        gnt    = '0;
        gnt_id = '0;
        any    = 1'b0;
        idx    = 0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            idx = (32'(ptr) + k) % NREQ;
            if (!any && req[idx]) begin
                any      = 1'b1;
                gnt[idx] = 1'b1;
                gnt_id   = ID_W'(idx);
            end
        end
    end

endmodule

// File: rtl/cla_share_arb.sv
// Shares one CLA_N adder among NREQ requesters: round-robin grant, one-cycle
// registered add, then a held response tagged with the requester ID.
module cla_share_arb
    import cla_pkg::*;
#(
    parameter int unsigned N    = CLA_N_DEF,
    parameter int unsigned NREQ = NREQ_DEF,
    parameter int unsigned ID_W = $clog2(NREQ)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*N-1:0] req_opa,
    input  logic [NREQ*N-1:0] req_opb,
    input  logic [NREQ-1:0]   req_cin,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [ID_W-1:0]   rsp_id,
    output logic [N-1:0]      rsp_sum,
    output logic              rsp_cout
);

    state_t          state;
    state_t          state_nxt;
    logic [ID_W-1:0] ptr;
    logic [NREQ-1:0] gnt;
    logic [ID_W-1:0] gnt_id;
    logic            any;
    logic            grant_ok;
    logic            take;
    logic [N-1:0]    op_a;
    logic [N-1:0]    op_b;
    logic            op_cin;
    logic [ID_W-1:0] op_id;
    logic [N-1:0]    add_sum;
    logic            add_cout;

    rr_arb #(.NREQ(NREQ), .ID_W(ID_W)) u_arb (
        .req    (req_valid),
        .ptr    (ptr),
        .gnt    (gnt),
        .gnt_id (gnt_id),
        .any    (any)
    );

    CLA_N #(.N(N)) u_cla (
        .A    (op_a),
        .B    (op_b),
        .CIN  (op_cin),
        .PHI  (1'b0),
        .SUM  (add_sum),
        .COUT (add_cout)
    );

    // A grant is possible from IDLE, or from HOLD in the cycle the response is taken.
    always_comb begin
        state_nxt = state;
        grant_ok  = 1'b0;
        case (state)
            ST_IDLE: begin
                grant_ok = 1'b1;
                if (any) state_nxt = ST_ADD;
            end
            ST_ADD:  state_nxt = ST_HOLD;
            ST_HOLD: begin
                if (rsp_ready) begin
                    grant_ok  = 1'b1;
                    state_nxt = any ? ST_ADD : ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
        take      = grant_ok && any && rst_n;
        req_ready = take ? gnt : '0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr       <= '0;
            op_a      <= '0;
            op_b      <= '0;
            op_cin    <= 1'b0;
            op_id     <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_sum   <= '0;
            rsp_cout  <= 1'b0;
        end else begin
            if (take) begin
                op_a   <= req_opa[req_pack(32'(gnt_id), N) +: N];
                op_b   <= req_opb[req_pack(32'(gnt_id), N) +: N];
                op_cin <= req_cin[gnt_id];
                op_id  <= gnt_id;
                ptr    <= (gnt_id == ID_W'(NREQ - 1)) ? '0 : gnt_id + 1'b1;
            end
            if (state == ST_ADD) begin
                rsp_valid <= 1'b1;
                rsp_sum   <= add_sum;
                rsp_cout  <= add_cout;
                rsp_id    <= op_id;
            end else if (state == ST_HOLD && rsp_ready) begin
                rsp_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_cla_share_arb.sv
// Directed bench for cla_share_arb with a cycle-level behavioural model and
// hand-computed expectations for the key scenarios.
module tb_cla_share_arb;

    localparam int unsigned N    = 32;
    localparam int unsigned NREQ = 4;
    localparam int unsigned ID_W = 2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*N-1:0] req_opa;
    logic [NREQ*N-1:0] req_opb;
    logic [NREQ-1:0]   req_cin;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [ID_W-1:0]   rsp_id;
    logic [N-1:0]      rsp_sum;
    logic              rsp_cout;

    cla_share_arb #(.N(N), .NREQ(NREQ), .ID_W(ID_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_opa   (req_opa),
        .req_opb   (req_opb),
        .req_cin   (req_cin),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_sum   (rsp_sum),
        .rsp_cout  (rsp_cout)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int gnt_q[$];
    int gnt_cyc[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Behavioural model: a busy flag for the add in progress plus the held result.
    int           m_ptr = 0;
    bit           m_inflight = 0;
    int           m_id = 0;
    logic [N-1:0] m_a = '0;
    logic [N-1:0] m_b = '0;
    bit           m_cin = 0;
    bit           m_rsp_valid = 0;
    int           m_rsp_id = 0;
    logic [N-1:0] m_rsp_sum = '0;
    bit           m_rsp_cout = 0;

    function automatic int mdl_winner();
        int idx;
        if (!rst_n) return -1;
        if (m_inflight || (m_rsp_valid && !rsp_ready)) return -1;
        for (int k = 0; k < NREQ; k++) begin
            idx = (m_ptr + k) % NREQ;
            if (req_valid[idx]) return idx;
        end
        return -1;
    endfunction

    always @(posedge clk) begin
        int         w;
        logic [N:0] s;
        cyc <= cyc + 1;
        w = mdl_winner();
        if (!rst_n) begin
            m_ptr <= 0; m_inflight <= 0; m_id <= 0; m_a <= '0; m_b <= '0; m_cin <= 0;
            m_rsp_valid <= 0; m_rsp_id <= 0; m_rsp_sum <= '0; m_rsp_cout <= 0;
        end else begin
            if (m_inflight) begin
                s = {1'b0, m_a} + {1'b0, m_b} + {{N{1'b0}}, m_cin};
                m_rsp_valid <= 1;
                m_rsp_sum   <= s[N-1:0];
                m_rsp_cout  <= s[N];
                m_rsp_id    <= m_id;
                m_inflight  <= 0;
            end else if (m_rsp_valid && rsp_ready) begin
                m_rsp_valid <= 0;
            end
            if (w >= 0) begin
                m_a        <= req_opa[w*N +: N];
                m_b        <= req_opb[w*N +: N];
                m_cin      <= req_cin[w];
                m_id       <= w;
                m_inflight <= 1;
                m_ptr      <= (w + 1) % NREQ;
            end
        end
    end

    always @(negedge clk) begin
        int              w;
        logic [NREQ-1:0] e;
        if (cyc > 0) begin
            w = mdl_winner();
            e = '0;
            if (w >= 0) e[w] = 1'b1;
            chk("req_ready", req_ready, e);
            chk("rsp_valid", rsp_valid, m_rsp_valid);
            if (m_rsp_valid) begin
                chk("rsp_id", rsp_id, m_rsp_id);
                chk("rsp_sum", rsp_sum, m_rsp_sum);
                chk("rsp_cout", rsp_cout, m_rsp_cout);
            end
            for (int i = 0; i < NREQ; i++) begin
                if (req_ready[i]) begin
                    gnt_q.push_back(i);
                    gnt_cyc.push_back(cyc);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_grants(input int n);
        int b = 0;
        while (gnt_q.size() < n && b < 40) begin
            step();
            b++;
        end
        if (gnt_q.size() < n) chk("grant_timeout", gnt_q.size(), n);
    endtask

    task automatic set_op(input int i, input logic [N-1:0] a, input logic [N-1:0] b, input logic c);
        req_opa[i*N +: N] = a;
        req_opb[i*N +: N] = b;
        req_cin[i]        = c;
    endtask

    function automatic int getq(input int i);
        if (i < gnt_q.size()) return gnt_q[i];
        return -1;
    endfunction

    initial begin
        rst_n = 1'b0; req_valid = '0; req_opa = '0; req_opb = '0; req_cin = '0; rsp_ready = 1'b0;
        step(); step();
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_sum", rsp_sum, 0);
        chk("rst_rsp_id", rsp_id, 0);
        chk("rst_rsp_cout", rsp_cout, 0);
        chk("rst_req_ready", req_ready, 0);

        // Carry chain through all 32 bits.
        step();
        set_op(0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
        req_valid = 4'b0001;
        @(negedge clk);
        chk("cc_grant", req_ready, 4'b0001);
        step(); req_valid = '0;
        step(); rsp_ready = 1'b1;
        @(negedge clk);
        chk("cc_valid", rsp_valid, 1);
        chk("cc_sum", rsp_sum, 32'h0000_0000);
        chk("cc_cout", rsp_cout, 1);
        chk("cc_id", rsp_id, 0);
        step(); rsp_ready = 1'b0;

        // Carry-in from requester 1.
        set_op(1, 32'h7FFF_FFFF, 32'h0000_0000, 1'b1);
        req_valid = 4'b0010;
        @(negedge clk);
        chk("ci_grant", req_ready, 4'b0010);
        step(); req_valid = '0;
        step(); rsp_ready = 1'b1;
        @(negedge clk);
        chk("ci_valid", rsp_valid, 1);
        chk("ci_sum", rsp_sum, 32'h8000_0000);
        chk("ci_cout", rsp_cout, 0);
        chk("ci_id", rsp_id, 1);
        step();

        // Pointer: req2 alone, then req0 and req3 together -> 3 before 0.
        gnt_q.delete(); gnt_cyc.delete();
        set_op(2, 32'h0000_0010, 32'h0000_0020, 1'b0);
        set_op(0, 32'h0000_0003, 32'h0000_0004, 1'b1);
        set_op(3, 32'hFFFF_FFF0, 32'h0000_0020, 1'b0);
        req_valid = 4'b0100;
        wait_grants(1);
        req_valid = 4'b1001;
        wait_grants(3);
        req_valid = '0;
        chk("ptr_first", getq(0), 2);
        chk("ptr_second", getq(1), 3);
        chk("ptr_third", getq(2), 0);
        step(); step(); step();

        // Backpressure: held response while req2 waits.
        rsp_ready = 1'b0;
        gnt_q.delete(); gnt_cyc.delete();
        set_op(0, 32'h1234_5678, 32'h1111_1111, 1'b1);
        req_valid = 4'b0001;
        wait_grants(1);
        set_op(2, 32'hA000_0000, 32'h6000_0000, 1'b0);
        req_valid = 4'b0100;
        step();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_ready", req_ready, 0);
            chk("bp_valid", rsp_valid, 1);
            chk("bp_sum", rsp_sum, 32'h2345_678A);
            chk("bp_id", rsp_id, 0);
            step();
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("bp_regrant", req_ready, 4'b0100);
        step(); req_valid = '0;
        step();
        @(negedge clk);
        chk("bp2_valid", rsp_valid, 1);
        chk("bp2_sum", rsp_sum, 32'h0000_0000);
        chk("bp2_cout", rsp_cout, 1);
        chk("bp2_id", rsp_id, 2);
        step();

        // Reset while in ADD drops the result and returns ptr to 0.
        rsp_ready = 1'b0;
        gnt_q.delete(); gnt_cyc.delete();
        set_op(0, 32'h0000_0005, 32'h0000_0006, 1'b0);
        req_valid = 4'b0001;
        wait_grants(1);
        rst_n = 1'b0; req_valid = '0;
        step();
        rst_n = 1'b1;
        set_op(1, 32'h0000_0100, 32'h0000_0001, 1'b0);
        set_op(3, 32'h0000_0200, 32'h0000_0002, 1'b1);
        req_valid = 4'b1010;
        gnt_q.delete(); gnt_cyc.delete();
        @(negedge clk);
        chk("rsa_valid", rsp_valid, 0);
        chk("rsa_sum", rsp_sum, 0);
        chk("rsa_id", rsp_id, 0);
        chk("rsa_cout", rsp_cout, 0);
        chk("rsa_first", req_ready, 4'b0010);
        step(); req_valid = 4'b1000; rsp_ready = 1'b1;
        wait_grants(2);
        req_valid = '0;
        chk("rsa_second", getq(1), 3);
        step(); step(); step();

        // req_ready forced low during reset, then fairness from ptr 0.
        rst_n = 1'b0;
        for (int i = 0; i < NREQ; i++) set_op(i, 32'h1000_0000 * (i + 1), 32'h0F0F_0F0F, i[0]);
        req_valid = 4'b1111;
        @(negedge clk);
        chk("rstlow_ready", req_ready, 0);
        step();
        rst_n = 1'b1;
        gnt_q.delete(); gnt_cyc.delete();
        wait_grants(8);
        req_valid = '0;
        for (int i = 0; i < 8; i++) chk("fair_id", getq(i), i % 4);
        for (int i = 1; i < 8 && i < gnt_cyc.size(); i++) chk("fair_gap", gnt_cyc[i] - gnt_cyc[i-1], 2);
        step(); step(); step(); step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
